round_referee: RTL and testbench

- Generates the per-round result stream consumed by the scorer in the reaction tug-of-war game.
- Inputs are synchronized, debounced player buttons; outputs are leds_on, winrnd, right and tie.
- Sequences each round: wait for release, random delay, LEDs on, first-press arbitration, result pulse.
- Contains a free-running LFSR that supplies the random delay.

---
 rtl/round_referee_pkg.sv | 21 ++
 rtl/rr_lfsr.sv | 20 ++
 rtl/round_referee.sv | 135 +++++++++++++
 tb/tb_round_referee.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/round_referee_pkg.sv
// Shared types and constants for the reaction-game round referee.
package round_referee_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ARMED,
        RESULT,
        HOLD
    } state_t;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/rr_lfsr.sv
// Free-running 16-bit Galois LFSR supplying the random start delay.
module rr_lfsr
    import round_referee_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/round_referee.sv
// Round sequencer: release wait, random delay, go LEDs, first-press arbitration, result pulse.
// Optional build macro ROUND_REFEREE_FALSE_START_EN awards a press during WAIT to the opponent.
module round_referee
    import round_referee_pkg::*;
#(
    parameter int unsigned       DELAY_MIN = 1000,
    parameter int unsigned       DELAY_W   = 10,
    parameter int unsigned       TIMEOUT   = 4095,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_l,
    input  logic pb_r,
    output logic leds_on,
    output logic winrnd,
    output logic right,
    output logic tie
);

    localparam int unsigned CNT_W = $clog2(DELAY_MIN + (1 << DELAY_W));
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic               pend_right, pend_right_d;
    logic               pend_tie, pend_tie_d;
    logic               leds_on_d, winrnd_d, right_d, tie_d;
    logic [LFSR_W-1:0]  lfsr;
    logic               any_pb;
    logic [CNT_W-1:0]   cnt_load;
    logic               unused_lfsr_hi;

    rr_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign any_pb         = pb_l | pb_r;
    assign cnt_load       = CNT_W'(DELAY_MIN) + CNT_W'(lfsr[DELAY_W-1:0]);
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:DELAY_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tmr        <= '0;
            pend_right <= 1'b0;
            pend_tie   <= 1'b0;
            leds_on    <= 1'b0;
            winrnd     <= 1'b0;
            right      <= 1'b0;
            tie        <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            tmr        <= tmr_d;
            pend_right <= pend_right_d;
            pend_tie   <= pend_tie_d;
            leds_on    <= leds_on_d;
            winrnd     <= winrnd_d;
            right      <= right_d;
            tie        <= tie_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        tmr_d        = tmr;
        pend_right_d = pend_right;
        pend_tie_d   = pend_tie;
        winrnd_d     = 1'b0;
        right_d      = right;
        tie_d        = tie;

        case (state)
            IDLE: begin
                if (!any_pb) begin
                    state_d = WAIT;
                    cnt_d   = cnt_load;
                end
            end
            WAIT: begin
                if (any_pb) begin
`ifdef ROUND_REFEREE_FALSE_START_EN
                    state_d      = RESULT;
                    pend_right_d = pb_l & ~pb_r;
                    pend_tie_d   = pb_l & pb_r;
`else
                    state_d      = IDLE;
`endif
                end else if (cnt <= CNT_W'(1)) begin
                    // WAIT occupies exactly cnt cycles before the LEDs light.
                    state_d = ARMED;
                    tmr_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ARMED: begin
                if (any_pb) begin
                    state_d      = RESULT;
                    pend_right_d = pb_r & ~pb_l;
                    pend_tie_d   = pb_l & pb_r;
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            RESULT: begin
                state_d  = HOLD;
                winrnd_d = 1'b1;
                right_d  = pend_right;
                tie_d    = pend_tie;
            end
            HOLD: begin
                if (!any_pb) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        leds_on_d = (state_d == ARMED);
    end

endmodule

// File: tb/tb_round_referee.sv
// Scoreboard bench for round_referee with short delays (DELAY_MIN=8, DELAY_W=3, TIMEOUT=20).
module tb_round_referee;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb_l = 1'b0;
    logic pb_r = 1'b0;
    logic leds_on, winrnd, right, tie;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected {right, tie} for each winrnd pulse, in order.
    logic [1:0] exp_q[$];

    round_referee #(
        .DELAY_MIN (8),
        .DELAY_W   (3),
        .TIMEOUT   (20),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_l    (pb_l),
        .pb_r    (pb_r),
        .leds_on (leds_on),
        .winrnd  (winrnd),
        .right   (right),
        .tie     (tie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for leds_on with a cycle budget; returns cycles waited.
    task automatic wait_leds(input int maxc, output int n);
        n = 0;
        while (!leds_on && n < maxc) begin
            tick();
            n++;
        end
        check("leds_wait_bound", int'(leds_on), 1);
    endtask

    // Monitor: every winrnd pulse must match the next queued result.
    always @(negedge clk) begin
        if (!rst && winrnd) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL spurious_winrnd: got right=%0d tie=%0d with no round pending", right, tie);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({right, tie} == e && leds_on == 1'b0) pass_cnt++;
                else $display("FAIL winrnd_result: got right=%0d tie=%0d leds=%0d expected right=%0d tie=%0d leds=0",
                              right, tie, leds_on, e[1], e[0]);
            end
        end
    end

    initial begin
        int n;
        int early;

        // Reset state
        repeat (3) tick();
        check("rst_outputs", int'({leds_on, winrnd, right, tie}), 0);
        rst = 1'b0;

        // First round: seed low bits = 1, so 9 cycles in WAIT -> leds after 10th edge
        tick();
        n = 1;
        check("pre_go_outputs", int'({leds_on, winrnd, right, tie}), 0);
        while (!leds_on && n < 40) begin
            tick();
            n++;
        end
        check("first_leds_latency", n, 10);

        // Right player presses for one cycle
        pb_r = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        check("leds_fall_on_press", int'(leds_on), 0);
        pb_r = 1'b0;
        repeat (3) tick();
        check("right_held", int'(right), 1);
        check("winrnd_single", int'(winrnd), 0);

        // Simultaneous press gives a tie; held buttons block a new round
        wait_leds(60, n);
        pb_l = 1'b1;
        pb_r = 1'b1;
        exp_q.push_back(2'b01);
        early = 0;
        repeat (12) begin
            tick();
            if (leds_on) early++;
        end
        check("tie_hold_no_leds", early, 0);
        check("tie_held", int'(tie), 1);
        pb_l = 1'b0;
        pb_r = 1'b0;

        // Left press held across RESULT: exactly one winrnd, no new round
        wait_leds(60, n);
        pb_l = 1'b1;
        exp_q.push_back(2'b00);
        early = 0;
        repeat (15) begin
            tick();
            if (leds_on) early++;
        end
        check("hold_no_leds", early, 0);
        check("hold_right_tie", int'({right, tie}), 0);
        pb_l = 1'b0;

        // False start: left press during WAIT
        repeat (3) tick();
        pb_l = 1'b1;
`ifdef ROUND_REFEREE_FALSE_START_EN
        exp_q.push_back(2'b10);
`endif
        tick();
        pb_l = 1'b0;
        early = 0;
        repeat (8) begin
            tick();
            if (leds_on) early++;
        end
        check("false_start_no_leds", early, 0);
        wait_leds(60, n);

        // Restarted round, right wins again
        pb_r = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        pb_r = 1'b0;

        // Timeout: 20 lit cycles, then dark, no winrnd
        wait_leds(60, n);
        n = 1;
        while (leds_on && n < 40) begin
            tick();
            n++;
        end
        check("timeout_lit_cycles", n - 1, 20);
        check("timeout_right_kept", int'(right), 1);

        // Reset mid-WAIT clears outputs at once and reloads the LFSR
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midround_rst_outputs", int'({leds_on, winrnd, right, tie}), 0);
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        while (!leds_on && n < 40) begin
            tick();
            n++;
        end
        check("reseed_leds_latency", n, 10);

        repeat (3) tick();
        check("pending_results", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
